pc_choose: RTL and testbench
============================

# pc_choose

Program-counter register with next-PC selection for the multicycle CPU. Each rising clock edge it loads one of three candidates: sequential PC+4, branch target, or jump target. Selection uses the decoded branch/jump controls and the ALU zero flag. It sits between the address-generation datapath (PC+4 adder, branch adder, jump concatenation) and instruction fetch.

## Interface
Parameters:
- WIDTH, 32 — address width in bits.
- RESET_VECTOR, 32'h0000_0000 — value PC takes during reset.

Ports:
- clk  input  1  — system clock; all updates on the rising edge.
- reset  input  1  — asynchronous, active-high reset; forces PC to RESET_VECTOR.
- PC4  input  WIDTH  — sequential next address (current PC + 4), computed externally.
- branchAddr  input  WIDTH  — branch target address, computed externally.
- jumpAddr  input  WIDTH  — jump target address, computed externally.
- beq  input  1  — current instruction is BEQ.
- bne  input  1  — current instruction is BNE.
- jump  input  1  — current instruction is an unconditional jump.
- zero  input  1  — ALU zero flag from the branch compare.
- PC  output  WIDTH  — registered program counter.

## Operation
- Branch-taken term: take = (beq & zero) | (bne & ~zero).
- Next-PC priority, highest first:
  - jump=1 -> jumpAddr
  - take=1 -> branchAddr
  - otherwise -> PC4
- jump has priority over any branch condition.
- beq=1 and bne=1 together makes take=1 regardless of zero; branchAddr is loaded (unless jump=1).
- Addresses pass through unmodified; no arithmetic is done inside the block.
- With reset=1, PC = RESET_VECTOR and all select inputs are ignored.

## Timing
- PC is a single WIDTH-bit register.
- Next-PC selection is purely combinational from the current inputs.
- Latency: the selected value appears on PC one rising edge after inputs are stable.
- No handshake; a load occurs on every non-reset rising edge, so the controller must hold inputs at the wanted values on non-fetch cycles.
- Reset assertion clears PC to RESET_VECTOR immediately, without waiting for a clock edge.
- PC holds RESET_VECTOR for as long as reset is high.
- First load after reset: the first rising edge with reset=0.
- Reset asserted between edges overrides any pending load.
- Reset value of the only output: PC = RESET_VECTOR (0 by default).

## Configuration
- Macro: PCCHOOSE_ALIGN_EN.
- When defined:
  - Bits [1:0] of the selected next-PC are forced to 0 before loading (word alignment).
  - Output misaligned (1 bit, registered, reset 0) is added. It is set on a load whose unmasked selected value had nonzero bits [1:0], and cleared on any aligned load.
- When undefined: the selected value loads unchanged and the misaligned port does not exist.

## Structure
- Shared package pc_pkg holds:
  - WIDTH default
  - RESET_VECTOR default
  - next-PC select encoding enum: SEL_PC4, SEL_BRANCH, SEL_JUMP
- Sub-module pc_next_sel is combinational: it takes beq, bne, jump, zero and outputs the select enum.
- The top level contains the 3:1 mux, the optional alignment mask and the register.

## Test plan
- Sequential: PC4=8, branchAddr=1, jumpAddr=2, beq=bne=jump=0, zero=0, clock edge -> PC=8.
- BNE taken: PC4=8, branchAddr=16, bne=1, zero=0, edge -> PC=16. Same with zero=1 -> PC=8.
- Jump: PC4=4, jumpAddr=20, jump=1, bne=1, zero=0, edge -> PC=20 (jump overrides branch).
- BEQ taken: PC4=4, branchAddr=32, beq=1, zero=1, edge -> PC=32. Same with zero=0 -> PC=4.
- Reset: load PC=32, then assert reset mid-cycle -> PC=0 before the next edge. With jump=1 or bne=1 and reset held across edges -> PC stays 0. Deassert reset with PC4=4 -> PC=4 after one edge.
- With PCCHOOSE_ALIGN_EN: branchAddr=33, beq=1, zero=1, edge -> PC=32 and misaligned=1. Next aligned load -> misaligned=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter block: default geometry and next-PC select encoding.
// Alignment support is controlled by the PCCHOOSE_ALIGN_EN macro in pc_choose.
package pc_pkg;

    localparam int unsigned PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_PC4    = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2
    } pc_sel_e;

    // Branch-taken term; beq and bne together always take.
    function automatic logic branch_take(input logic beq, input logic bne, input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC source selection from decoded branch/jump controls and the ALU zero flag.
// Jump outranks any branch condition.
module pc_next_sel
    import pc_pkg::*;
(
    input  logic    beq,
    input  logic    bne,
    input  logic    jump,
    input  logic    zero,
    output pc_sel_e sel
);

    always_comb begin
        sel = SEL_PC4;
        if (jump) begin
            sel = SEL_JUMP;
        end else if (branch_take(beq, bne, zero)) begin
            sel = SEL_BRANCH;
        end
    end

endmodule

// File: rtl/pc_choose.sv
// Program-counter register loading PC+4, branch target or jump target on every rising edge.
// Define PCCHOOSE_ALIGN_EN to word-align loads and add the registered misaligned flag.
module pc_choose
    import pc_pkg::*;
#(
    parameter int unsigned           WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0]      RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] PC4,
    input  logic [WIDTH-1:0] branchAddr,
    input  logic [WIDTH-1:0] jumpAddr,
    input  logic             beq,
    input  logic             bne,
    input  logic             jump,
    input  logic             zero,
`ifdef PCCHOOSE_ALIGN_EN
    output logic             misaligned,
`endif
    output logic [WIDTH-1:0] PC
);

    pc_sel_e          sel;
    logic [WIDTH-1:0] next_raw;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;

    pc_next_sel u_pc_next_sel (
        .beq  (beq),
        .bne  (bne),
        .jump (jump),
        .zero (zero),
        .sel  (sel)
    );

    always_comb begin
        next_raw = PC4;
        unique case (sel)
            SEL_PC4:    next_raw = PC4;
            SEL_BRANCH: next_raw = branchAddr;
            SEL_JUMP:   next_raw = jumpAddr;
            default:    next_raw = PC4;
        endcase
    end

`ifdef PCCHOOSE_ALIGN_EN
    logic misaligned_d;
    logic misaligned_q;

    always_comb begin
        pc_d         = {next_raw[WIDTH-1:2], 2'b00};
        misaligned_d = |next_raw[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign misaligned = misaligned_q;
`else
    always_comb begin
        pc_d = next_raw;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_pc_choose.sv
// Directed self-checking bench for pc_choose; covers PCCHOOSE_ALIGN_EN when that macro is defined.
module tb_pc_choose;

    logic        clk;
    logic        reset;
    logic [31:0] PC4;
    logic [31:0] branchAddr;
    logic [31:0] jumpAddr;
    logic        beq;
    logic        bne;
    logic        jump;
    logic        zero;
    logic [31:0] PC;
`ifdef PCCHOOSE_ALIGN_EN
    logic        misaligned;
`endif

    int n_checks;
    int n_errors;

    pc_choose #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PC4        (PC4),
        .branchAddr (branchAddr),
        .jumpAddr   (jumpAddr),
        .beq        (beq),
        .bne        (bne),
        .jump       (jump),
        .zero       (zero),
`ifdef PCCHOOSE_ALIGN_EN
        .misaligned (misaligned),
`endif
        .PC         (PC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] p4, input logic [31:0] br, input logic [31:0] jp,
                          input logic b_eq, input logic b_ne, input logic j, input logic z);
        PC4        = p4;
        branchAddr = br;
        jumpAddr   = jp;
        beq        = b_eq;
        bne        = b_ne;
        jump       = j;
        zero       = z;
    endtask

    // Apply inputs away from the edge, clock once, then check PC just after the edge.
    task automatic step(input string tag, input logic [31:0] p4, input logic [31:0] br,
                        input logic [31:0] jp, input logic b_eq, input logic b_ne,
                        input logic j, input logic z, input logic [31:0] exp);
        @(negedge clk);
        set_in(p4, br, jp, b_eq, b_ne, j, z);
        @(posedge clk);
        #1;
        check_eq(tag, PC, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        set_in(32'd8, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("reset_async", PC, 32'd0);
`ifdef PCCHOOSE_ALIGN_EN
        check_eq("reset_misaligned", {31'd0, misaligned}, 32'd0);
`endif
        @(posedge clk);
        #1;
        check_eq("reset_held_edge", PC, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        //     tag              PC4           branchAddr    jumpAddr      beq   bne   jump  zero  expect
        step("sequential",     32'd8,        32'd1,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0, 32'd8);
        step("bne_taken",      32'd8,        32'd16,       32'd2,        1'b0, 1'b1, 1'b0, 1'b0, 32'd16);
        step("bne_not_taken",  32'd8,        32'd16,       32'd2,        1'b0, 1'b1, 1'b0, 1'b1, 32'd8);
        step("jump_over_bne",  32'd4,        32'd16,       32'd20,       1'b0, 1'b1, 1'b1, 1'b0, 32'd20);
        step("beq_taken",      32'd4,        32'd32,       32'd20,       1'b1, 1'b0, 1'b0, 1'b1, 32'd32);
        step("beq_not_taken",  32'd4,        32'd32,       32'd20,       1'b1, 1'b0, 1'b0, 1'b0, 32'd4);
        step("beq_bne_z0",     32'd4,        32'd36,       32'd20,       1'b1, 1'b1, 1'b0, 1'b0, 32'd36);
        step("beq_bne_z1",     32'd12,       32'd40,       32'd20,       1'b1, 1'b1, 1'b0, 1'b1, 32'd40);
        step("jump_over_beq",  32'd4,        32'd32,       32'd44,       1'b1, 1'b0, 1'b1, 1'b1, 32'd44);
        step("wide_jump",      32'd4,        32'd32,       32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0,
             32'hFFFF_FFFC);
        step("wide_pc4",       32'hA5A5_5A58, 32'd32,      32'd44,       1'b0, 1'b0, 1'b0, 1'b1,
             32'hA5A5_5A58);

        // Mid-cycle reset clears PC before the next edge and holds it across edges.
        step("load_before_rst", 32'd4,       32'd32,       32'd20,       1'b1, 1'b0, 1'b0, 1'b1, 32'd32);
        #3;
        reset = 1'b1;
        #1;
        check_eq("reset_mid_cycle", PC, 32'd0);
        step("reset_hold_jump", 32'd4,       32'd32,       32'd20,       1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        step("reset_hold_bne",  32'd4,       32'd32,       32'd20,       1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("first_after_rst", 32'd4,       32'd32,       32'd20,       1'b0, 1'b0, 1'b0, 1'b0, 32'd4);

`ifdef PCCHOOSE_ALIGN_EN
        step("align_branch",    32'd4,       32'd33,       32'd20,       1'b1, 1'b0, 1'b0, 1'b1, 32'd32);
        check_eq("misaligned_set", {31'd0, misaligned}, 32'd1);
        step("align_jump",      32'd4,       32'd32,       32'd23,       1'b0, 1'b0, 1'b1, 1'b0, 32'd20);
        check_eq("misaligned_hold", {31'd0, misaligned}, 32'd1);
        step("aligned_load",    32'd36,      32'd33,       32'd23,       1'b0, 1'b0, 1'b0, 1'b0, 32'd36);
        check_eq("misaligned_clr", {31'd0, misaligned}, 32'd0);
`else
        step("unaligned_branch", 32'd4,      32'd33,       32'd20,       1'b1, 1'b0, 1'b0, 1'b1, 32'd33);
        step("unaligned_jump",   32'd4,      32'd32,       32'd23,       1'b0, 1'b0, 1'b1, 1'b0, 32'd23);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
